// File: rtl/uart_tx_frame_if.sv
// Byte-request and serial-line bundle between a UART TX client and uart_tx_frame.
interface uart_tx_frame_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  Data_Valid;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic                  TX_OUT;
   logic                  busy;

   modport master (output P_DATA, Data_Valid, PAR_EN, PAR_TYP, input TX_OUT, busy);
   modport slave  (input P_DATA, Data_Valid, PAR_EN, PAR_TYP, output TX_OUT, busy);
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: one clk per bit, start / data LSB-first / optional parity / stop.
module uart_tx_frame #(
   parameter int DATA_WIDTH = 8
) (
   input  logic            clk,
   input  logic            rst,
   uart_tx_frame_if.slave  tx
);
   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic                  par_en;
      logic                  par;
   } frame_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   frame_t          frame_q, frame_nxt;
   logic            tx_q, tx_nxt;
   logic            busy_q, busy_nxt;
   logic            accept;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         frame_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         frame_q <= frame_nxt;
         tx_q    <= tx_nxt;
         busy_q  <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      frame_nxt = frame_q;
      accept    = (state == IDLE || state == STOP) && tx.Data_Valid;

      case (state)
         IDLE, STOP: state_nxt = accept ? START : IDLE;
         START: begin
            state_nxt = DATA;
            cnt_nxt   = '0;
         end
         DATA: begin
            if (cnt == CW'(DATA_WIDTH - 1)) begin
               cnt_nxt   = '0;
               state_nxt = frame_q.par_en ? PARITY : STOP;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         PARITY:  state_nxt = STOP;
         default: state_nxt = IDLE;
      endcase

      if (accept) begin
         frame_nxt.data   = tx.P_DATA;
         frame_nxt.par_en = tx.PAR_EN;
         frame_nxt.par    = tx.PAR_TYP ? ~^tx.P_DATA : ^tx.P_DATA;
      end

      // Outputs are registered, so drive the bit belonging to the state being entered.
      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = frame_q.data[cnt_nxt];
         PARITY:  tx_nxt = frame_q.par;
         default: tx_nxt = 1'b1;
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   assign tx.TX_OUT = tx_q;
   assign tx.busy   = busy_q;
endmodule
